// File: rtl/gate_lab_pkg.sv
// Shared types and helpers for the gate lab sweep checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gate_lab_pkg;

  localparam int MAX_WIDTH    = 8;
  localparam int MAX_CHANNELS = 16;
  localparam int MAX_SETTLE   = 15;
  localparam int SETTLE_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } sweepState_t;

  // Reflected binary Gray code; callers zero-extend narrower indices.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Pattern index for the sweep: binary or Gray ordering, last-pattern flag.
// Latency: stimulus follows the index register combinationally (0 cycles).
// Backpressure: none; advances only when the controller asks.
//
// Ports:
//   clk, reset      clock, async active-high reset
//   restart         reload index to 0 and latch grayIn
//   grayIn          ordering requested with restart (1 = Gray)
//   advance         step index by one
//   stimulus        current pattern
//   lastPattern     index is at 2^WIDTH-1
module pattern_gen
  import gate_lab_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             grayIn,
  input  logic             advance,
  output logic [WIDTH-1:0] stimulus,
  output logic             lastPattern
);

  localparam logic [WIDTH:0] LastIdx = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] IdxOne  = (WIDTH+1)'(1);

  logic [WIDTH:0] idx;
  logic           grayMode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      grayMode <= 1'b0;
    end else if (restart) begin
      idx      <= '0;
      grayMode <= grayIn;
    end else if (advance) begin
      idx <= idx + IdxOne;
    end
  end

  // Index never exceeds LastIdx, so the low WIDTH bits carry the pattern.
  assign stimulus    = grayMode ? WIDTH'(bin2gray(MAX_WIDTH'(idx[WIDTH-1:0])))
                                : idx[WIDTH-1:0];
  assign lastPattern = (idx == LastIdx);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all 2^WIDTH patterns into CHANNELS gate implementations and checks them against a golden response.
// Latency: done pulses 1 + 2^WIDTH*(SETTLE+1) cycles after the accepted start.
// Backpressure: none; start is dropped unless the checker is idle.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   start, gray_mode    sweep request (idle only) and ordering select
//   stimulus            pattern driven to every implementation
//   resp_dut, resp_ref  per-channel responses and golden response
//   busy, done          sweep in progress / one-cycle end pulse
//   pass, mismatch_count, first_fail_pattern, first_fail_mask   sweep result
module gate_sweep_checker
  import gate_lab_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 3,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                gray_mode,
  output logic [WIDTH-1:0]    stimulus,
  input  logic [CHANNELS-1:0] resp_dut,
  input  logic                resp_ref,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [WIDTH:0]      mismatch_count,
  output logic [WIDTH-1:0]    first_fail_pattern,
  output logic [CHANNELS-1:0] first_fail_mask
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : gWidthCheck
    $error("gate_sweep_checker: WIDTH out of range");
  end
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : gChannelCheck
    $error("gate_sweep_checker: CHANNELS out of range");
  end
  if (SETTLE < 1 || SETTLE > MAX_SETTLE) begin : gSettleCheck
    $error("gate_sweep_checker: SETTLE out of range");
  end

  localparam logic [SETTLE_BITS-1:0] SettleLoad = SETTLE_BITS'(SETTLE - 1);
  localparam logic [SETTLE_BITS-1:0] SettleOne  = SETTLE_BITS'(1);
  localparam logic [WIDTH:0]         CountOne   = (WIDTH+1)'(1);

  sweepState_t                state;
  sweepState_t                nextState;
  logic [SETTLE_BITS-1:0]     settleCnt;
  logic [CHANNELS-1:0]        failVec;
  logic                       lastPattern;
  logic                       acceptStart;
  logic                       advance;

  assign acceptStart = (state == IDLE) && start;
  assign advance     = (state == SAMPLE) && !lastPattern;

  pattern_gen #(
    .WIDTH (WIDTH)
  ) uPatternGen (
    .clk         (clk),
    .reset       (reset),
    .restart     (acceptStart),
    .grayIn      (gray_mode),
    .advance     (advance),
    .stimulus    (stimulus),
    .lastPattern (lastPattern)
  );

  // Case inequality so an X/Z on either side flags the channel as failing.
  always_comb begin
    failVec = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      failVec[c] = (resp_dut[c] !== resp_ref);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = APPLY;
      APPLY:   if (settleCnt == '0) nextState = SAMPLE;
      SAMPLE:  nextState = lastPattern ? DONE : APPLY;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Settle counter and result registers. The verdict is resolved on the
  // final SAMPLE edge so it is already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settleCnt          <= '0;
      pass               <= 1'b0;
      mismatch_count     <= '0;
      first_fail_pattern <= '0;
      first_fail_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            settleCnt          <= SettleLoad;
            pass               <= 1'b0;
            mismatch_count     <= '0;
            first_fail_pattern <= '0;
            first_fail_mask    <= '0;
          end
        end
        APPLY: begin
          if (settleCnt != '0) settleCnt <= settleCnt - SettleOne;
        end
        SAMPLE: begin
          if (failVec != '0) begin
            mismatch_count <= mismatch_count + CountOne;
            // A zero count means no earlier pattern failed in this sweep.
            if (mismatch_count == '0) begin
              first_fail_pattern <= stimulus;
              first_fail_mask    <= failVec;
            end
          end
          if (lastPattern) pass <= (mismatch_count == '0) && (failVec == '0);
          else             settleCnt <= SettleLoad;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (binary/W2/S1, Gray/W3/S1, binary/W2/S4) with behavioural labs.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_sweep_checker;

  typedef struct {
    int   cnt;
    int   pat;
    int   mask;
    int   passExp;
    int   doneAt;
  } expResult_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset, startA, startG, startS;
  logic grayOff, grayOn;
  int   faultMode;
  int   curSel;
  int   checkCount = 0;
  int   errorCount = 0;

  logic [1:0] stimA, ffPatA, stimS, ffPatS;
  logic [2:0] stimG, ffPatG;
  logic [2:0] cntA, cntS;
  logic [3:0] cntG;
  logic [2:0] dutA, dutG, dutS, maskA, maskG, maskS;
  logic       refA, refG, refS;
  logic       busyA, busyG, busyS, doneA, doneG, doneS, passA, passG, passS;

  logic [7:0]  obsStim, obsPat;
  logic [8:0]  obsCnt;
  logic [15:0] obsMask;
  logic        obsBusy, obsDone, obsPass;

  logic [7:0] stimQ[$];
  expResult_t resQ[$];

  // Lab model: golden AND (or XOR for the Gray lab) plus three channels.
  // fault 0: all correct, 1: channel 1 is an OR, 2: all channels stuck at 1.
  function automatic logic [3:0] labModel(input logic [7:0] stim, input bit useXor, input int fault);
    logic       r;
    logic [2:0] d;
    r = useXor ? ^stim : (stim[0] & stim[1]);
    case (fault)
      1:       d = {r, stim[0] | stim[1], r};
      2:       d = 3'b111;
      default: d = {3{r}};
    endcase
    return {r, d};
  endfunction

  always_comb {refA, dutA} = labModel(8'(stimA), 1'b0, faultMode);
  always_comb {refG, dutG} = labModel(8'(stimG), 1'b1, faultMode);
  always_comb {refS, dutS} = labModel(8'(stimS), 1'b0, faultMode);

  gate_sweep_checker #(.WIDTH(2), .CHANNELS(3), .SETTLE(1)) dutBin (
    .clk(clk), .reset(reset), .start(startA), .gray_mode(grayOff),
    .stimulus(stimA), .resp_dut(dutA), .resp_ref(refA),
    .busy(busyA), .done(doneA), .pass(passA), .mismatch_count(cntA),
    .first_fail_pattern(ffPatA), .first_fail_mask(maskA));

  gate_sweep_checker #(.WIDTH(3), .CHANNELS(3), .SETTLE(1)) dutGray (
    .clk(clk), .reset(reset), .start(startG), .gray_mode(grayOn),
    .stimulus(stimG), .resp_dut(dutG), .resp_ref(refG),
    .busy(busyG), .done(doneG), .pass(passG), .mismatch_count(cntG),
    .first_fail_pattern(ffPatG), .first_fail_mask(maskG));

  gate_sweep_checker #(.WIDTH(2), .CHANNELS(3), .SETTLE(4)) dutSlow (
    .clk(clk), .reset(reset), .start(startS), .gray_mode(grayOff),
    .stimulus(stimS), .resp_dut(dutS), .resp_ref(refS),
    .busy(busyS), .done(doneS), .pass(passS), .mismatch_count(cntS),
    .first_fail_pattern(ffPatS), .first_fail_mask(maskS));

  always_comb begin
    case (curSel)
      1: begin
        obsStim = 8'(stimG); obsPat = 8'(ffPatG); obsCnt = 9'(cntG); obsMask = 16'(maskG);
        obsBusy = busyG; obsDone = doneG; obsPass = passG;
      end
      2: begin
        obsStim = 8'(stimS); obsPat = 8'(ffPatS); obsCnt = 9'(cntS); obsMask = 16'(maskS);
        obsBusy = busyS; obsDone = doneS; obsPass = passS;
      end
      default: begin
        obsStim = 8'(stimA); obsPat = 8'(ffPatA); obsCnt = 9'(cntA); obsMask = 16'(maskA);
        obsBusy = busyA; obsDone = doneA; obsPass = passA;
      end
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic setStart(input int sel, input logic v);
    case (sel)
      1:       startG = v;
      2:       startS = v;
      default: startA = v;
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".stim"}, 32'(obsStim), 0);
    checkVal({tag, ".busy"}, 32'(obsBusy), 0);
    checkVal({tag, ".done"}, 32'(obsDone), 0);
    checkVal({tag, ".pass"}, 32'(obsPass), 0);
    checkVal({tag, ".cnt"},  32'(obsCnt),  0);
    checkVal({tag, ".pat"},  32'(obsPat),  0);
    checkVal({tag, ".mask"}, 32'(obsMask), 0);
  endtask

  // sel: 0 binary W2 S1, 1 Gray W3 S1, 2 binary W2 S4.
  // abort: pulse start during pattern 2, reset during pattern 3 (sel 0 only).
  // startInDone: request a start in the done cycle, which must be ignored.
  task automatic runSweep(input int sel, input int fault, input bit abort, input bit startInDone);
    int         w, s, t, k;
    bit         gray, finished, sawActivity;
    logic [7:0] p;
    logic [3:0] m;
    expResult_t e;
    w = (sel == 1) ? 3 : 2;
    s = (sel == 2) ? 4 : 1;
    gray = (sel == 1);
    curSel = sel;
    faultMode = fault;
    e.cnt = 0; e.pat = 0; e.mask = 0;
    for (int i = 0; i < (1 << w); i++) begin
      p = gray ? 8'(i ^ (i >> 1)) : 8'(i);
      m = labModel(p, gray, fault);
      for (int j = 0; j <= s; j++) stimQ.push_back(p);
      if (m[2:0] != {3{m[3]}}) begin
        if (e.cnt == 0) begin
          e.pat  = int'(p);
          e.mask = int'(m[2:0] ^ {3{m[3]}});
        end
        e.cnt++;
      end
    end
    e.passExp = (e.cnt == 0) ? 1 : 0;

    @(posedge clk); #1;
    t = cyc;
    setStart(sel, 1'b1);
    e.doneAt = t + 1 + (1 << w) * (s + 1);
    resQ.push_back(e);
    @(posedge clk); #1;
    setStart(sel, 1'b0);

    finished = 1'b0;
    for (int n = 0; n < 200 && !finished; n++) begin
      @(negedge clk);
      k = cyc - t;
      if (abort && k == 5) setStart(sel, 1'b1);
      if (abort && k == 6) setStart(sel, 1'b0);
      if (abort && k == 7) begin
        reset = 1'b1;
        #1;
        checkAllZero("abortReset");
        finished = 1'b1;
      end else if (obsDone) begin
        e = resQ.pop_front();
        checkVal("doneCycle", 32'(cyc), 32'(e.doneAt));
        checkVal("mismatchCount", 32'(obsCnt), 32'(e.cnt));
        checkVal("firstFailPattern", 32'(obsPat), 32'(e.pat));
        checkVal("firstFailMask", 32'(obsMask), 32'(e.mask));
        checkVal("pass", 32'(obsPass), 32'(e.passExp));
        checkVal("stimLeft", 32'(stimQ.size()), 0);
        if (startInDone) setStart(sel, 1'b1);
        finished = 1'b1;
      end else begin
        checkVal("busy", 32'(obsBusy), 1);
        if (stimQ.size() == 0) checkVal("stimExtra", 1, 0);
        else                   checkVal("stim", 32'(obsStim), 32'(stimQ.pop_front()));
      end
    end
    if (!finished) checkVal("doneTimeout", 0, 1);

    if (abort) begin
      stimQ.delete();
      resQ.delete();
      @(negedge clk);
      reset = 1'b0;
      sawActivity = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (obsDone || obsBusy) sawActivity = 1'b1;
      end
      checkVal("abortQuiet", 32'(sawActivity), 0);
    end else begin
      stimQ.delete();
      resQ.delete();
      @(negedge clk);
      if (startInDone) setStart(sel, 1'b0);
      checkVal("busyFall", 32'(obsBusy), 0);
      checkVal("passHeld", 32'(obsPass), 32'(e.passExp));
      checkVal("countHeld", 32'(obsCnt), 32'(e.cnt));
      if (startInDone) begin
        repeat (3) begin
          @(negedge clk);
          checkVal("startInDoneIgnored", 32'(obsBusy), 0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    startA = 1'b0; startG = 1'b0; startS = 1'b0;
    grayOff = 1'b0; grayOn = 1'b1;
    faultMode = 0;
    curSel = 0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    runSweep(0, 0, 1'b0, 1'b1);  // AND, all correct, start during done ignored
    runSweep(0, 1, 1'b0, 1'b0);  // channel 1 forced OR
    runSweep(1, 0, 1'b0, 1'b0);  // Gray order, XOR lab
    runSweep(2, 0, 1'b0, 1'b0);  // SETTLE=4
    runSweep(0, 1, 1'b1, 1'b0);  // mid-sweep start then reset
    runSweep(0, 0, 1'b0, 1'b0);  // clean sweep after the abort
    runSweep(0, 2, 1'b0, 1'b0);  // all channels stuck at 1

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
